// File: rtl/led_seq_pkg.sv
// Shared state encodings, LED patterns and mode decode for the LED pattern sequencer.
package led_seq_pkg;

    typedef enum logic [1:0] {
        S_PASS  = 2'd0,
        S_BLINK = 2'd1,
        S_CHASE = 2'd2,
        S_COUNT = 2'd3
    } state_e;

    localparam logic [3:0] BLINK_A    = 4'b1111;
    localparam logic [3:0] BLINK_B    = 4'b0110;
    localparam logic [3:0] CHASE_INIT = 4'b0001;
    localparam logic [3:0] COUNT_INIT = 4'b0000;

    // Only switches 3 and 0 select the mode.
    function automatic state_e decode_mode(input logic [3:0] ps);
        state_e m;
        case ({ps[3], ps[0]})
            2'b00:   m = S_BLINK;
            2'b10:   m = S_CHASE;
            2'b01:   m = S_COUNT;
            default: m = S_PASS;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// Switch/LED bundle between the board pins and the LED pattern sequencer.
interface led_pattern_sequencer_if;
    logic [3:0] P;
    logic [3:0] L;
    logic       tick;
    logic [1:0] mode;

    modport master (output P, input L, input tick, input mode);
    modport slave  (input P, output L, output tick, output mode);
endinterface

// File: rtl/tick_divider.sv
// Prescaler: tick is high while cnt == TICK_DIV-1; clr restarts the count and beats the wrap.
module tick_divider #(
    parameter int unsigned TICK_DIV = 25_000_000,
    parameter int unsigned CNT_W    = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CntMax);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED bank mode controller: pass-through, blink, chase and binary count on prescaler ticks.
// Optional switch debouncer enabled by defining DEBOUNCE_EN.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 25_000_000,
    parameter int unsigned CNT_W     = 25,
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input logic                     clk,
    input logic                     rst,
    led_pattern_sequencer_if.slave  bus
);

    if (TICK_DIV < 2 || DB_CYCLES < 1) begin : g_bad_params
        $error("led_pattern_sequencer: TICK_DIV must be >= 2 and DB_CYCLES >= 1");
    end

    logic [3:0] p_meta_q, ps_q, ps_eff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_meta_q <= '0;
            ps_q     <= '0;
        end else begin
            p_meta_q <= bus.P;
            ps_q     <= p_meta_q;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int unsigned DbW = $clog2(DB_CYCLES + 1);

    logic [3:0]     ps_last_q, ps_db_q;
    logic [DbW-1:0] db_cnt_q;

    // db_cnt_q counts consecutive cycles ps_q has matched its previous value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps_last_q <= '0;
            ps_db_q   <= '0;
            db_cnt_q  <= '0;
        end else begin
            ps_last_q <= ps_q;
            if (ps_q != ps_last_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q != DbW'(DB_CYCLES - 1)) begin
                db_cnt_q <= db_cnt_q + DbW'(1);
            end else begin
                ps_db_q <= ps_last_q;
            end
        end
    end

    assign ps_eff = ps_db_q;
`else
    assign ps_eff = ps_q;
`endif

    state_e     state_q, state_d;
    logic [3:0] led_q, led_d;
    logic       phase_q, phase_d;
    logic       mode_chg, tick;

    tick_divider #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_tick_divider (
        .clk  (clk),
        .rst  (rst),
        .clr  (mode_chg),
        .tick (tick)
    );

    always_comb begin
        state_d  = decode_mode(ps_eff);
        mode_chg = (state_d != state_q);
        led_d    = led_q;
        phase_d  = phase_q;
        if (mode_chg) begin
            // A mode change swallows any tick landing in the same cycle.
            phase_d = 1'b0;
            unique case (state_d)
                S_PASS:  led_d = ps_eff;
                S_BLINK: led_d = BLINK_A;
                S_CHASE: led_d = CHASE_INIT;
                S_COUNT: led_d = COUNT_INIT;
            endcase
        end else begin
            unique case (state_q)
                S_PASS:  led_d = ps_eff;
                S_BLINK: begin
                    if (tick) begin
                        phase_d = ~phase_q;
                        led_d   = phase_q ? BLINK_A : BLINK_B;
                    end
                end
                S_CHASE: begin
                    if (tick) led_d = {led_q[2:0], led_q[3]};
                end
                S_COUNT: begin
                    if (tick) led_d = led_q + 4'd1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_PASS;
            led_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            phase_q <= phase_d;
        end
    end

    assign bus.L    = led_q;
    assign bus.tick = tick;
    assign bus.mode = state_q;

endmodule
